// File: rtl/m_ps2_scancode_decoder_pkg.sv
// Shared constants, state encodings and helpers for the PS/2 scan-code decoder.
package m_ps2_scancode_decoder_pkg;

  localparam logic [7:0] PS2_PFX_E0 = 8'hE0;
  localparam logic [7:0] PS2_PFX_F0 = 8'hF0;
  localparam logic [7:0] PS2_PFX_E1 = 8'hE1;
  localparam logic [7:0] KEY_PAUSE  = 8'd119;

  localparam logic [2:0] SCD_S_IDLE      = 3'd0;
  localparam logic [2:0] SCD_S_E0        = 3'd1;
  localparam logic [2:0] SCD_S_F0        = 3'd2;
  localparam logic [2:0] SCD_S_E0F0      = 3'd3;
  localparam logic [2:0] SCD_S_E1        = 3'd4;
  localparam logic [2:0] SCD_S_PAUSE_REL = 3'd5;

  // Bytes that follow E1 before the pause make is reported.
  localparam logic [2:0] E1_SKIP = 3'd7;

  // Sideband carried alongside the registered keymap lookup.
  typedef struct packed {
    logic vld;
    logic press;
    logic pause;
    logic zero;
    logic fake;
  } lk_meta_t;

  // Keyboard status/ack bytes that never form part of a key sequence.
  function automatic logic is_ignored(input logic [7:0] b);
    return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hFE) || (b == 8'hEE) ||
           (b == 8'h00) || (b == 8'hFF);
  endfunction

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == PS2_PFX_E0) || (b == PS2_PFX_F0) || (b == PS2_PFX_E1);
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] inc);
    logic [8:0] s;
    s = {1'b0, a} + {7'b0, inc};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/m_ps2_keymap_rom.sv
// Scan-code set 2 to Linux keycode lookup; normal and E0 tables, one-cycle registered output.
module m_ps2_keymap_rom (
  input  logic       CLK,
  input  logic       RST_X,
  input  logic       i_ext,
  input  logic [6:0] i_code,
  output logic [7:0] o_keycode
);

  logic [7:0] norm_kc;
  logic [7:0] ext_kc;
  logic [7:0] kc_d;
  logic [7:0] kc_q;

  // Slot 02 is unused in set 2; the top level steers F7 (83) into it.
  always_comb begin
    norm_kc = 8'h0;
    case (i_code)
      7'h01: norm_kc = 8'd67;   7'h02: norm_kc = 8'd65;
      7'h03: norm_kc = 8'd63;   7'h04: norm_kc = 8'd61;
      7'h05: norm_kc = 8'd59;   7'h06: norm_kc = 8'd60;
      7'h07: norm_kc = 8'd88;   7'h09: norm_kc = 8'd68;
      7'h0A: norm_kc = 8'd66;   7'h0B: norm_kc = 8'd64;
      7'h0C: norm_kc = 8'd62;   7'h0D: norm_kc = 8'd15;
      7'h0E: norm_kc = 8'd41;   7'h11: norm_kc = 8'd56;
      7'h12: norm_kc = 8'd42;   7'h14: norm_kc = 8'd29;
      7'h15: norm_kc = 8'd16;   7'h16: norm_kc = 8'd2;
      7'h1A: norm_kc = 8'd44;   7'h1B: norm_kc = 8'd31;
      7'h1C: norm_kc = 8'd30;   7'h1D: norm_kc = 8'd17;
      7'h1E: norm_kc = 8'd3;    7'h21: norm_kc = 8'd46;
      7'h22: norm_kc = 8'd45;   7'h23: norm_kc = 8'd32;
      7'h24: norm_kc = 8'd18;   7'h25: norm_kc = 8'd5;
      7'h26: norm_kc = 8'd4;    7'h29: norm_kc = 8'd57;
      7'h2A: norm_kc = 8'd47;   7'h2B: norm_kc = 8'd33;
      7'h2C: norm_kc = 8'd20;   7'h2D: norm_kc = 8'd19;
      7'h2E: norm_kc = 8'd6;    7'h31: norm_kc = 8'd49;
      7'h32: norm_kc = 8'd48;   7'h33: norm_kc = 8'd35;
      7'h34: norm_kc = 8'd34;   7'h35: norm_kc = 8'd21;
      7'h36: norm_kc = 8'd7;    7'h3A: norm_kc = 8'd50;
      7'h3B: norm_kc = 8'd36;   7'h3C: norm_kc = 8'd22;
      7'h3D: norm_kc = 8'd8;    7'h3E: norm_kc = 8'd9;
      7'h41: norm_kc = 8'd51;   7'h42: norm_kc = 8'd37;
      7'h43: norm_kc = 8'd23;   7'h44: norm_kc = 8'd24;
      7'h45: norm_kc = 8'd11;   7'h46: norm_kc = 8'd10;
      7'h49: norm_kc = 8'd52;   7'h4A: norm_kc = 8'd53;
      7'h4B: norm_kc = 8'd38;   7'h4C: norm_kc = 8'd39;
      7'h4D: norm_kc = 8'd25;   7'h4E: norm_kc = 8'd12;
      7'h52: norm_kc = 8'd40;   7'h54: norm_kc = 8'd26;
      7'h55: norm_kc = 8'd13;   7'h58: norm_kc = 8'd58;
      7'h59: norm_kc = 8'd54;   7'h5A: norm_kc = 8'd28;
      7'h5B: norm_kc = 8'd27;   7'h5D: norm_kc = 8'd43;
      7'h61: norm_kc = 8'd86;   7'h66: norm_kc = 8'd14;
      7'h69: norm_kc = 8'd79;   7'h6B: norm_kc = 8'd75;
      7'h6C: norm_kc = 8'd71;   7'h70: norm_kc = 8'd82;
      7'h71: norm_kc = 8'd83;   7'h72: norm_kc = 8'd80;
      7'h73: norm_kc = 8'd76;   7'h74: norm_kc = 8'd77;
      7'h75: norm_kc = 8'd72;   7'h76: norm_kc = 8'd1;
      7'h77: norm_kc = 8'd69;   7'h78: norm_kc = 8'd87;
      7'h79: norm_kc = 8'd78;   7'h7A: norm_kc = 8'd81;
      7'h7B: norm_kc = 8'd74;   7'h7C: norm_kc = 8'd55;
      7'h7D: norm_kc = 8'd73;   7'h7E: norm_kc = 8'd70;
      default: norm_kc = 8'h0;
    endcase
  end

  // E0 12 / E0 59 are fake shifts and deliberately stay unmapped.
  always_comb begin
    ext_kc = 8'h0;
    case (i_code)
      7'h11: ext_kc = 8'd100;   7'h14: ext_kc = 8'd97;
      7'h1F: ext_kc = 8'd125;   7'h27: ext_kc = 8'd126;
      7'h2F: ext_kc = 8'd127;   7'h37: ext_kc = 8'd116;
      7'h3F: ext_kc = 8'd142;   7'h4A: ext_kc = 8'd98;
      7'h5A: ext_kc = 8'd96;    7'h5E: ext_kc = 8'd143;
      7'h69: ext_kc = 8'd107;   7'h6B: ext_kc = 8'd105;
      7'h6C: ext_kc = 8'd102;   7'h70: ext_kc = 8'd110;
      7'h71: ext_kc = 8'd111;   7'h72: ext_kc = 8'd108;
      7'h74: ext_kc = 8'd106;   7'h75: ext_kc = 8'd103;
      7'h7A: ext_kc = 8'd109;   7'h7C: ext_kc = 8'd99;
      7'h7D: ext_kc = 8'd104;
      default: ext_kc = 8'h0;
    endcase
  end

  assign kc_d = i_ext ? ext_kc : norm_kc;

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      kc_q <= 8'h0;
    end else begin
      kc_q <= kc_d;
    end
  end

  assign o_keycode = kc_q;

endmodule

// File: rtl/m_ps2_scancode_decoder.sv
// PS/2 set-2 sequence parser: prefix FSM, keymap lookup, pause sequencer, event FIFO and stats.
module m_ps2_scancode_decoder
  import m_ps2_scancode_decoder_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned TIMEOUT_CYC  = 2000000,
  parameter logic [7:0]  KEY_PAUSE_CD = 8'd119
) (
  input  logic        CLK,
  input  logic        RST_X,
  input  logic        i_rx_en,
  input  logic [7:0]  i_rx_data,
  output logic        o_ev_valid,
  output logic [15:0] o_ev_data,
  input  logic        i_ev_ready,
  output logic [7:0]  o_drop_cnt,
  output logic [7:0]  o_ovf_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [2:0]  state_q, state_d;
  logic [2:0]  skip_q, skip_d;
  logic [31:0] tmo_q, tmo_d;
  lk_meta_t    lk_q, lk_d;
  logic        lk_ext;
  logic [6:0]  rom_idx;
  logic [7:0]  rom_kc;
  logic        drop_pfx;
  logic        tmo_fire;
  logic        reproc;
  logic [2:0]  idle_state;
  logic        idle_lookup;

  logic [7:0]  ev_code;
  logic        push_req, push, pop, ovf, drop_lk, full, empty;
  logic [8:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [7:0]  drop_q, drop_d, ovf_q, ovf_d;
  logic [1:0]  drop_inc;

  // What a byte means when seen with no prefix pending.
  always_comb begin
    idle_state  = SCD_S_IDLE;
    idle_lookup = 1'b0;
    if (i_rx_data == PS2_PFX_E0) begin
      idle_state = SCD_S_E0;
    end else if (i_rx_data == PS2_PFX_F0) begin
      idle_state = SCD_S_F0;
    end else if (i_rx_data == PS2_PFX_E1) begin
      idle_state = SCD_S_E1;
    end else if (!is_ignored(i_rx_data)) begin
      idle_lookup = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    tmo_d    = tmo_q;
    lk_d     = '0;
    lk_ext   = 1'b0;
    drop_pfx = 1'b0;
    tmo_fire = 1'b0;
    reproc   = 1'b0;

    case (state_q)
      SCD_S_IDLE: begin
        reproc = i_rx_en;
      end
      SCD_S_E0: begin
        if (i_rx_en) begin
          if (i_rx_data == PS2_PFX_F0) begin
            state_d = SCD_S_E0F0;
          end else if (is_prefix(i_rx_data)) begin
            drop_pfx = 1'b1;
            reproc   = 1'b1;
          end else begin
            lk_d.vld   = 1'b1;
            lk_d.press = 1'b1;
            lk_ext     = 1'b1;
            state_d    = SCD_S_IDLE;
          end
        end
      end
      SCD_S_F0, SCD_S_E0F0: begin
        if (i_rx_en) begin
          if (is_prefix(i_rx_data)) begin
            drop_pfx = 1'b1;
            reproc   = 1'b1;
          end else begin
            lk_d.vld = 1'b1;
            lk_ext   = (state_q == SCD_S_E0F0);
            state_d  = SCD_S_IDLE;
          end
        end
      end
      SCD_S_E1: begin
        if (i_rx_en) begin
          if (skip_q == 3'd1) begin
            lk_d.vld   = 1'b1;
            lk_d.press = 1'b1;
            lk_d.pause = 1'b1;
            state_d    = SCD_S_PAUSE_REL;
          end else begin
            skip_d = skip_q - 3'd1;
          end
        end
      end
      SCD_S_PAUSE_REL: begin
        // The lookup stage is busy with the pause break, so a byte here is lost.
        lk_d.vld   = 1'b1;
        lk_d.pause = 1'b1;
        drop_pfx   = i_rx_en;
        state_d    = SCD_S_IDLE;
      end
      default: begin
        state_d = SCD_S_IDLE;
      end
    endcase

    if (reproc) begin
      state_d = idle_state;
      if (idle_state == SCD_S_E1) begin
        skip_d = E1_SKIP;
      end
      if (idle_lookup) begin
        lk_d.vld   = 1'b1;
        lk_d.press = 1'b1;
        lk_ext     = 1'b0;
      end
    end

    if (i_rx_en || (state_q == SCD_S_IDLE) || (state_q == SCD_S_PAUSE_REL)) begin
      tmo_d = 32'd0;
    end else if (tmo_q == 32'(TIMEOUT_CYC - 1)) begin
      tmo_fire = 1'b1;
      tmo_d    = 32'd0;
      state_d  = SCD_S_IDLE;
    end else begin
      tmo_d = tmo_q + 32'd1;
    end

    // F7 is the only set-2 code above 7F; it is folded into the unused normal slot 02.
    lk_d.zero = (i_rx_data[7] && !(i_rx_data == 8'h83 && !lk_ext)) ||
                (!lk_ext && i_rx_data == 8'h02);
    lk_d.fake = lk_ext && (i_rx_data == 8'h12 || i_rx_data == 8'h59);
  end

  assign rom_idx = (!lk_ext && i_rx_data == 8'h83) ? 7'h02 : i_rx_data[6:0];

  m_ps2_keymap_rom u_keymap (
    .CLK       (CLK),
    .RST_X     (RST_X),
    .i_ext     (lk_ext),
    .i_code    (rom_idx),
    .o_keycode (rom_kc)
  );

  always_comb begin
    ev_code  = lk_q.pause ? KEY_PAUSE_CD : (lk_q.zero ? 8'h0 : rom_kc);
    push_req = lk_q.vld && (ev_code != 8'h0);
    drop_lk  = lk_q.vld && (ev_code == 8'h0) && !lk_q.fake;

    empty = (cnt_q == '0);
    full  = (cnt_q == (AW + 1)'(FIFO_DEPTH));
    pop   = !empty && i_ev_ready;
    push  = push_req && (!full || pop);
    ovf   = push_req && full && !pop;

    head_d = head_q + AW'(pop);
    tail_d = tail_q + AW'(push);
    cnt_d  = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + (AW + 1)'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - (AW + 1)'(1);
    end

    drop_inc = {1'b0, drop_pfx} + {1'b0, drop_lk} + {1'b0, tmo_fire};
    drop_d   = sat_add8(drop_q, drop_inc);
    ovf_d    = sat_add8(ovf_q, {1'b0, ovf});
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q <= SCD_S_IDLE;
      skip_q  <= 3'd0;
      tmo_q   <= 32'd0;
      lk_q    <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      drop_q  <= 8'h0;
      ovf_q   <= 8'h0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      tmo_q   <= tmo_d;
      lk_q    <= lk_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[tail_q] <= {lk_q.press, ev_code};
    end
  end

  assign o_ev_valid = !empty;
  assign o_ev_data  = empty ? 16'h0 : {7'h0, mem_q[head_q]};
  assign o_drop_cnt = drop_q;
  assign o_ovf_cnt  = ovf_q;

endmodule

// File: tb/tb_m_ps2_scancode_decoder.sv
// Directed self-checking bench for the PS/2 scan-code decoder.
module tb_m_ps2_scancode_decoder;

  localparam int unsigned TMO = 40;

  logic        CLK = 1'b0;
  logic        RST_X = 1'b0;
  logic        i_rx_en = 1'b0;
  logic [7:0]  i_rx_data = 8'h0;
  logic        o_ev_valid;
  logic [15:0] o_ev_data;
  logic        i_ev_ready = 1'b0;
  logic [7:0]  o_drop_cnt;
  logic [7:0]  o_ovf_cnt;

  int checks = 0;
  int errors = 0;

  m_ps2_scancode_decoder #(
    .FIFO_DEPTH   (8),
    .TIMEOUT_CYC  (TMO),
    .KEY_PAUSE_CD (8'd119)
  ) dut (
    .CLK        (CLK),
    .RST_X      (RST_X),
    .i_rx_en    (i_rx_en),
    .i_rx_data  (i_rx_data),
    .o_ev_valid (o_ev_valid),
    .o_ev_data  (o_ev_data),
    .i_ev_ready (i_ev_ready),
    .o_drop_cnt (o_drop_cnt),
    .o_ovf_cnt  (o_ovf_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic send_byte(input logic [7:0] b);
    @(negedge CLK);
    i_rx_en   = 1'b1;
    i_rx_data = b;
    @(posedge CLK);
    #1 i_rx_en = 1'b0;
  endtask

  // Waits (bounded) for an event and pops it.
  task automatic get_event(input int max_cyc, output logic got, output logic [15:0] d);
    got = 1'b0;
    d   = 16'h0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      @(negedge CLK);
      if (o_ev_valid) begin
        got = 1'b1;
        d   = o_ev_data;
        i_ev_ready = 1'b1;
        @(posedge CLK);
        #1 i_ev_ready = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (o_ev_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", o_ev_valid);
    end
    checks++;
    if (o_ev_data !== 16'h0) begin
      errors++; $display("FAIL reset_data: got %h expected 0000", o_ev_data);
    end
    checks++;
    if (o_drop_cnt !== 8'h0) begin
      errors++; $display("FAIL reset_drop: got %h expected 00", o_drop_cnt);
    end
    checks++;
    if (o_ovf_cnt !== 8'h0) begin
      errors++; $display("FAIL reset_ovf: got %h expected 00", o_ovf_cnt);
    end
    repeat (2) @(negedge CLK);
    RST_X = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_make_break();
    logic got;
    logic [15:0] d;
    send_byte(8'h1C);
    @(negedge CLK);
    checks++;
    if (o_ev_valid !== 1'b0) begin
      errors++; $display("FAIL latency_n1: got valid %b expected 0", o_ev_valid);
    end
    @(negedge CLK);
    checks++;
    if (o_ev_valid !== 1'b1 || o_ev_data !== 16'h011E) begin
      errors++; $display("FAIL latency_n2: got %b/%h expected 1/011e", o_ev_valid, o_ev_data);
    end
    get_event(5, got, d);
    checks++;
    if (!got || d !== 16'h011E) begin
      errors++; $display("FAIL a_make: got %b/%h expected 1/011e", got, d);
    end
    send_byte(8'hF0);
    send_byte(8'h1C);
    get_event(10, got, d);
    checks++;
    if (!got || d !== 16'h001E) begin
      errors++; $display("FAIL a_break: got %b/%h expected 1/001e", got, d);
    end
    checks++;
    if (o_drop_cnt !== 8'h0) begin
      errors++; $display("FAIL mb_drop: got %h expected 00", o_drop_cnt);
    end
  endtask

  task automatic test_extended();
    logic got;
    logic [15:0] d;
    send_byte(8'hE0); send_byte(8'h75);
    get_event(10, got, d);
    checks++;
    if (!got || d !== 16'h0167) begin
      errors++; $display("FAIL up_make: got %b/%h expected 1/0167", got, d);
    end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    get_event(10, got, d);
    checks++;
    if (!got || d !== 16'h0067) begin
      errors++; $display("FAIL up_break: got %b/%h expected 1/0067", got, d);
    end
    send_byte(8'hE0); send_byte(8'h12); send_byte(8'hE0); send_byte(8'h7C);
    get_event(10, got, d);
    checks++;
    if (!got || d !== 16'h0163) begin
      errors++; $display("FAIL sysrq: got %b/%h expected 1/0163", got, d);
    end
    get_event(6, got, d);
    checks++;
    if (got) begin
      errors++; $display("FAIL sysrq_extra: got event %h expected none", d);
    end
    checks++;
    if (o_drop_cnt !== 8'h0) begin
      errors++; $display("FAIL fake_shift_drop: got %h expected 00", o_drop_cnt);
    end
  endtask

  task automatic test_pause();
    logic [7:0] seq [8];
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    i_ev_ready = 1'b1;
    for (int i = 0; i < 8; i++) send_byte(seq[i]);
    @(negedge CLK);
    checks++;
    if (o_ev_valid !== 1'b0) begin
      errors++; $display("FAIL pause_early: got valid %b expected 0", o_ev_valid);
    end
    @(negedge CLK);
    checks++;
    if (o_ev_valid !== 1'b1 || o_ev_data !== 16'h0177) begin
      errors++; $display("FAIL pause_make: got %b/%h expected 1/0177", o_ev_valid, o_ev_data);
    end
    @(negedge CLK);
    checks++;
    if (o_ev_valid !== 1'b1 || o_ev_data !== 16'h0077) begin
      errors++; $display("FAIL pause_break: got %b/%h expected 1/0077", o_ev_valid, o_ev_data);
    end
    @(negedge CLK);
    checks++;
    if (o_ev_valid !== 1'b0) begin
      errors++; $display("FAIL pause_extra: got valid %b data %h expected 0", o_ev_valid, o_ev_data);
    end
    i_ev_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [7:0] codes [10];
    codes = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42, 8'h4B, 8'h4C};
    i_ev_ready = 1'b0;
    for (int i = 0; i < 10; i++) send_byte(codes[i]);
    repeat (4) @(negedge CLK);
    checks++;
    if (o_ovf_cnt !== 8'd2) begin
      errors++; $display("FAIL ovf_cnt: got %0d expected 2", o_ovf_cnt);
    end
    for (int i = 0; i < 8; i++) begin
      if (i != 0) @(negedge CLK);
      i_ev_ready = 1'b1;
      checks++;
      if (o_ev_valid !== 1'b1 || o_ev_data !== (16'h011E + 16'(i))) begin
        errors++;
        $display("FAIL drain_%0d: got %b/%h expected 1/%h", i, o_ev_valid, o_ev_data,
                 16'h011E + 16'(i));
      end
    end
    @(negedge CLK);
    checks++;
    if (o_ev_valid !== 1'b0) begin
      errors++; $display("FAIL drain_empty: got valid %b expected 0", o_ev_valid);
    end
    i_ev_ready = 1'b0;
  endtask

  task automatic test_timeout();
    logic got;
    logic [15:0] d;
    send_byte(8'hF0);
    repeat (TMO + 3) @(negedge CLK);
    checks++;
    if (o_drop_cnt !== 8'd1) begin
      errors++; $display("FAIL tmo_drop: got %0d expected 1", o_drop_cnt);
    end
    send_byte(8'h1C);
    get_event(10, got, d);
    checks++;
    if (!got || d !== 16'h011E) begin
      errors++; $display("FAIL tmo_make: got %b/%h expected 1/011e", got, d);
    end
  endtask

  task automatic test_illegal();
    logic got;
    logic [15:0] d;
    send_byte(8'hF0); send_byte(8'hE0); send_byte(8'h75);
    get_event(10, got, d);
    checks++;
    if (!got || d !== 16'h0167) begin
      errors++; $display("FAIL reproc_up: got %b/%h expected 1/0167", got, d);
    end
    checks++;
    if (o_drop_cnt !== 8'd2) begin
      errors++; $display("FAIL illegal_drop: got %0d expected 2", o_drop_cnt);
    end
    send_byte(8'h60);
    send_byte(8'hAA);
    get_event(6, got, d);
    checks++;
    if (got) begin
      errors++; $display("FAIL unmapped_event: got event %h expected none", d);
    end
    checks++;
    if (o_drop_cnt !== 8'd3) begin
      errors++; $display("FAIL unmapped_drop: got %0d expected 3", o_drop_cnt);
    end
    send_byte(8'h83);
    get_event(10, got, d);
    checks++;
    if (!got || d !== 16'h0141) begin
      errors++; $display("FAIL f7_make: got %b/%h expected 1/0141", got, d);
    end
  endtask

  task automatic test_reset_mid_sequence();
    logic got;
    logic [15:0] d;
    send_byte(8'h1C);
    send_byte(8'hE0);
    repeat (2) @(negedge CLK);
    RST_X = 1'b0;
    #1;
    checks++;
    if (o_ev_valid !== 1'b0 || o_drop_cnt !== 8'h0 || o_ovf_cnt !== 8'h0) begin
      errors++;
      $display("FAIL midrst_flush: got valid %b drop %h ovf %h expected 0/00/00",
               o_ev_valid, o_drop_cnt, o_ovf_cnt);
    end
    @(negedge CLK);
    RST_X = 1'b1;
    send_byte(8'h74);
    get_event(10, got, d);
    checks++;
    if (!got || d !== 16'h014D) begin
      errors++; $display("FAIL midrst_kp6: got %b/%h expected 1/014d", got, d);
    end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_extended();
    test_pause();
    test_overflow();
    test_timeout();
    test_illegal();
    test_reset_mid_sequence();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
